// File: rtl/multi_cycle_control_pkg.sv
// Shared defines for the multi-cycle controller: opcodes, state encodings,
// instruction classes and ALU operation class constants.
package multi_cycle_control_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // CLS_NOP doubles as the reset value and the class of unknown opcodes.
    typedef enum logic [3:0] {
        CLS_NOP    = 4'd0,
        CLS_R      = 4'd1,
        CLS_I      = 4'd2,
        CLS_LOAD   = 4'd3,
        CLS_STORE  = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_LUI    = 4'd6,
        CLS_AUIPC  = 4'd7,
        CLS_JAL    = 4'd8,
        CLS_JALR   = 4'd9
    } op_class_t;

    localparam logic [2:0] ALU_NOP    = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_BRANCH = 3'b001;
    localparam logic [2:0] ALU_R      = 3'b010;
    localparam logic [2:0] ALU_I      = 3'b011;
    localparam logic [2:0] ALU_LUI    = 3'b100;
    localparam logic [2:0] ALU_AUIPC  = 3'b101;
    localparam logic [2:0] ALU_JUMP   = 3'b110;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       src1;
        logic       src2;
    } exec_ctrl_t;

    function automatic op_class_t decode_class(input logic [6:0] op);
        case (op)
            OP_R:      return CLS_R;
            OP_I:      return CLS_I;
            OP_LOAD:   return CLS_LOAD;
            OP_STORE:  return CLS_STORE;
            OP_BRANCH: return CLS_BRANCH;
            OP_LUI:    return CLS_LUI;
            OP_AUIPC:  return CLS_AUIPC;
            OP_JAL:    return CLS_JAL;
            OP_JALR:   return CLS_JALR;
            default:   return CLS_NOP;
        endcase
    endfunction

    function automatic exec_ctrl_t exec_ctrl(input op_class_t cls);
        exec_ctrl_t c;
        c.alu_op = ALU_NOP;
        c.src1   = 1'b0;
        c.src2   = 1'b0;
        case (cls)
            CLS_R:      c.alu_op = ALU_R;
            CLS_I:      begin c.alu_op = ALU_I;     c.src2 = 1'b1; end
            CLS_LOAD,
            CLS_STORE:  begin c.alu_op = ALU_ADD;   c.src2 = 1'b1; end
            CLS_BRANCH: c.alu_op = ALU_BRANCH;
            CLS_LUI:    begin c.alu_op = ALU_LUI;   c.src2 = 1'b1; end
            CLS_AUIPC:  begin c.alu_op = ALU_AUIPC; c.src1 = 1'b1; c.src2 = 1'b1; end
            CLS_JAL:    begin c.alu_op = ALU_JUMP;  c.src1 = 1'b1; c.src2 = 1'b1; end
            CLS_JALR:   begin c.alu_op = ALU_JUMP;  c.src2 = 1'b1; end
            default:    ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multi_cycle_control_wait_timer.sv
// Wait counter for memory handshakes: clears on request, counts enabled
// cycles and flags timeout once it reaches WAIT_MAX-1.
module multi_cycle_control_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CNT_W = $clog2(WAIT_MAX);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_MAX - 1);

    logic [CNT_W-1:0] count;

    // Saturates at LAST; the controller clears it on the timeout cycle anyway.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !timeout) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (count == LAST);

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory wait timeout.
// Optional: define MULTI_CYCLE_CONTROL_ILLEGAL_TRAP_EN to trap unknown opcodes.
module multi_cycle_control
    import multi_cycle_control_pkg::*;
#(
    parameter int ALUOP_W  = 3,
    parameter int WAIT_MAX = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [6:0]         i_OPCode,
    input  logic               i_IMemReady,
    input  logic               i_DMemReady,
    input  logic               i_Stall,
    output logic [2:0]         o_State,
    output logic               o_IMemRead,
    output logic               o_IRWrite,
    output logic               o_PCWrite,
    output logic               o_Jump,
    output logic               o_Branch,
    output logic               o_MemRead,
    output logic               o_MemWrite,
    output logic               o_MemToReg,
    output logic               o_ALUSrc1,
    output logic               o_ALUSrc2,
    output logic               o_RegWrite,
    output logic [ALUOP_W-1:0] o_ALUOp,
    output logic               o_Illegal,
    output logic               o_BusErr
);

    state_t     state, state_next;
    op_class_t  cls;
    exec_ctrl_t ctrl;
    logic       post_rst, quiet;
    logic       waiting, ready_sel, timeout, wait_clear, wait_en;
    logic       imem_read, ir_write, pc_write, jump, branch;
    logic       mem_read, mem_write, mem_to_reg, src1, src2, reg_write, bus_err;
    logic [2:0] alu_op;
`ifdef MULTI_CYCLE_CONTROL_ILLEGAL_TRAP_EN
    logic       trap_seen, illegal;
`endif

    // The reset cycle and the one after it are silent: nothing is strobed.
    assign quiet = i_rst | post_rst;
    assign ctrl  = exec_ctrl(cls);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_FETCH;
            cls      <= CLS_NOP;
            post_rst <= 1'b1;
        end else begin
            state    <= state_next;
            post_rst <= 1'b0;
            if (state == ST_DECODE && !i_Stall) begin
                cls <= decode_class(i_OPCode);
            end
        end
    end

`ifdef MULTI_CYCLE_CONTROL_ILLEGAL_TRAP_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            trap_seen <= 1'b0;
        end else if (illegal) begin
            trap_seen <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_next = state;
        waiting    = 1'b0;
        ready_sel  = 1'b0;
        imem_read  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        src1       = 1'b0;
        src2       = 1'b0;
        reg_write  = 1'b0;
        bus_err    = 1'b0;
        alu_op     = ALU_NOP;
`ifdef MULTI_CYCLE_CONTROL_ILLEGAL_TRAP_EN
        illegal    = 1'b0;
`endif
        if (!quiet) begin
            case (state)
                ST_FETCH: begin
                    waiting   = 1'b1;
                    ready_sel = i_IMemReady;
                    imem_read = 1'b1;
                    if (i_IMemReady) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        if (!i_Stall) state_next = ST_DECODE;
                    end else if (timeout && !i_Stall) begin
                        imem_read = 1'b0;
                        bus_err   = 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (!i_Stall) begin
`ifdef MULTI_CYCLE_CONTROL_ILLEGAL_TRAP_EN
                        state_next = (decode_class(i_OPCode) == CLS_NOP) ? ST_TRAP : ST_EXEC;
`else
                        state_next = ST_EXEC;
`endif
                    end
                end
                ST_EXEC: begin
                    alu_op = ctrl.alu_op;
                    src1   = ctrl.src1;
                    src2   = ctrl.src2;
                    case (cls)
                        CLS_BRANCH: begin
                            branch = 1'b1;
                            if (!i_Stall) state_next = ST_FETCH;
                        end
                        CLS_JAL, CLS_JALR: begin
                            jump     = 1'b1;
                            pc_write = 1'b1;
                            if (!i_Stall) state_next = ST_WB;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            if (!i_Stall) state_next = ST_MEM;
                        end
                        CLS_NOP: begin
                            if (!i_Stall) state_next = ST_FETCH;
                        end
                        default: begin
                            if (!i_Stall) state_next = ST_WB;
                        end
                    endcase
                end
                ST_MEM: begin
                    waiting   = 1'b1;
                    ready_sel = i_DMemReady;
                    mem_read  = (cls == CLS_LOAD);
                    mem_write = (cls == CLS_STORE);
                    if (i_DMemReady) begin
                        if (!i_Stall) state_next = (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
                    end else if (timeout && !i_Stall) begin
                        mem_read   = 1'b0;
                        mem_write  = 1'b0;
                        bus_err    = 1'b1;
                        state_next = ST_FETCH;
                    end
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (cls == CLS_LOAD);
                    if (!i_Stall) state_next = ST_FETCH;
                end
`ifdef MULTI_CYCLE_CONTROL_ILLEGAL_TRAP_EN
                ST_TRAP: begin
                    illegal = !trap_seen;
                end
`endif
                default: state_next = ST_FETCH;
            endcase
        end
    end

    // Leaving any state (or a timeout) restarts the count for the next wait.
    assign wait_clear = (state_next != state) | bus_err;
    assign wait_en    = waiting & ~ready_sel & ~i_Stall;

    multi_cycle_control_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (wait_clear),
        .enable  (wait_en),
        .timeout (timeout)
    );

    assign o_State    = state;
    assign o_IMemRead = imem_read;
    assign o_IRWrite  = ir_write  & ~i_Stall;
    assign o_PCWrite  = pc_write  & ~i_Stall;
    assign o_Jump     = jump      & ~i_Stall;
    assign o_Branch   = branch    & ~i_Stall;
    assign o_MemRead  = mem_read;
    assign o_MemWrite = mem_write & ~i_Stall;
    assign o_MemToReg = mem_to_reg;
    assign o_ALUSrc1  = src1;
    assign o_ALUSrc2  = src2;
    assign o_RegWrite = reg_write & ~i_Stall;
    assign o_ALUOp    = ALUOP_W'(alu_op);
    assign o_BusErr   = bus_err;
`ifdef MULTI_CYCLE_CONTROL_ILLEGAL_TRAP_EN
    assign o_Illegal  = illegal;
`else
    assign o_Illegal  = 1'b0;
`endif

endmodule
